lock_sequencer: RTL
===================

Name: lock_sequencer

Overview:
Door-lock control FSM that produces the `state` code and 8-digit `seq` word consumed by the seven-segment/RGB display driver. It takes debounced, single-cycle keypad strobes, captures an 8-digit passcode in INIT, checks entered digits one at a time (LS0..LS7), and raises OPEN or ALARM. The state encoding is shared with the display: LS0..LS7=0..7, OPEN=8, ALARM=9, INIT=10.

Parameters:
MAX_FAILS, 3, consecutive wrong digits that trigger ALARM (1..15)
OPEN_CYCLES, 24'd10_000_000, clock cycles OPEN is held before auto-relock
ALARM_CYCLES, 24'd16_000_000, clock cycles ALARM is held before returning to LS0
TIMER_W, 24, width of the shared OPEN/ALARM down-counter

Ports:
clk  in  1  system clock, rising-edge
nrst  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe; key_code is valid in this cycle
key_code  in  4  0x0-0x9 digit, 0xA SET, 0xB LOCK, 0xC CLEAR, 0xD-0xF ignored
state  out  4  current FSM state code (0-10)
seq  out  32  entry buffer; digit k occupies seq[4k+3:4k]
unlock  out  1  high exactly while state==OPEN
alarm  out  1  high exactly while state==ALARM

Behaviour:
- Reset (nrst low, asynchronous): state=INIT(10), seq=0, password=0, digit count=0, fail count=0, timer=0, unlock=0, alarm=0.
- All outputs are registered. A key strobe sampled at edge N is reflected on the outputs after edge N.
- Every key is acted on once. When key_valid is low, key_code is ignored.
- INIT:
  - Digit with count<8: written to seq[4*count +: 4], count++.
  - Digit with count==8: ignored.
  - CLEAR: seq=0, count=0.
  - SET with count==8: password<=seq, seq=0, count=0, fail=0, go to LS0.
  - SET with count<8: ignored.
  - LOCK: ignored.
- LSn (n=0..7):
  - Digit equal to password[4n+3:4n]: go to LS(n+1). In LS7, go to OPEN and load timer=OPEN_CYCLES-1.
  - Digit not equal: fail++. If the new fail==MAX_FAILS, go to ALARM and load timer=ALARM_CYCLES-1. Otherwise go to LS0.
  - CLEAR or LOCK: go to LS0; fail count unchanged.
  - SET: ignored.
  - seq mirrors the digits entered in the current attempt (same packing) so the display can echo them. seq clears on any return to LS0.
- OPEN:
  - Timer decrements every cycle. At timer==0: go to LS0, fail=0.
  - LOCK: go to LS0 immediately, fail=0.
  - SET: go to INIT, seq=0, count=0. The password register is kept until the next valid SET in INIT.
  - Digits and CLEAR: ignored.
- ALARM:
  - All keys ignored.
  - Timer decrements. At timer==0: go to LS0, fail=0.
  - Only nrst or the timeout exits ALARM.
- Simultaneous timer==0 and key_valid in OPEN: timeout wins and the key is dropped.
- fail saturates and never wraps. It is reset on successful OPEN, on timeouts, on entry to LS0 from INIT, and by nrst.
- Timer loads are TIMER_W bits and truncate silently. OPEN_CYCLES and ALARM_CYCLES must be ≥1.
- Illegal state codes (11-15) recover to INIT on the next edge.
- nrst asserted mid-entry or mid-timer aborts immediately to reset values. The password is lost.

Test Plan:
1. Reset, enter 1,2,3,4,5,6,7,8, then SET -> seq reads 0x87654321 before SET; after SET, state=0 and seq=0. Then enter 1..8 -> state steps 1..7, then 8 with unlock=1. OPEN_CYCLES=5 -> state=0 and unlock=0 exactly 5 cycles after OPEN entry.
2. Program 0x87654321, enter 1,2,9 -> state returns to 0 and fail=1. Repeat twice more (MAX_FAILS=3) -> state=9, alarm=1. Keys during ALARM are ignored. After ALARM_CYCLES=4 -> state=0, alarm=0.
3. In INIT enter 5 digits, then SET -> no state change. Enter CLEAR -> seq=0. Enter 9 digits -> only the first 8 are stored.
4. In OPEN, press LOCK -> state=0 next cycle. From a second OPEN, press SET -> state=10, seq=0. Program new code 0x11111111 -> the old code fails and the new code opens.
5. Key strobe in the same cycle the OPEN timer hits 0 -> state=0 and the key has no effect. Pulse nrst while in LS4 -> state=10, seq=0, outputs low.
6. Force state to 4'hF via a bench override/deposit -> state=10 on the next edge.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: door-lock control FSM feeding the seven-segment/RGB display driver.
// In INIT it captures an 8-digit passcode. In LS0..LS7 it checks the entered digits one
// at a time. A full match raises OPEN; too many consecutive wrong digits raise ALARM.
// Both OPEN and ALARM time out back to LS0 using one shared down-counter.
//
// Ports:
//   clk        system clock, rising edge
//   nrst       asynchronous active-low reset
//   key_valid  one-cycle key strobe
//   key_code   0-9 digit, A SET, B LOCK, C CLEAR, D-F ignored
//   state      state code shared with the display (LS0..LS7=0..7, OPEN=8, ALARM=9, INIT=10)
//   seq        entry buffer; digit k sits in seq[4k+3:4k]
//   unlock     high while in OPEN
//   alarm      high while in ALARM
module lock_sequencer #(
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned OPEN_CYCLES  = 24'd10_000_000,
  parameter int unsigned ALARM_CYCLES = 24'd16_000_000,
  parameter int unsigned TIMER_W      = 24
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  state,
  output logic [31:0] seq,
  output logic        unlock,
  output logic        alarm
);

  // Codes are fixed by the display driver.
  typedef enum logic [3:0] {
    StLs0   = 4'd0,
    StLs1   = 4'd1,
    StLs2   = 4'd2,
    StLs3   = 4'd3,
    StLs4   = 4'd4,
    StLs5   = 4'd5,
    StLs6   = 4'd6,
    StLs7   = 4'd7,
    StOpen  = 4'd8,
    StAlarm = 4'd9,
    StInit  = 4'd10
  } state_e;

  localparam logic [3:0]         KeySet    = 4'hA;
  localparam logic [3:0]         KeyLock   = 4'hB;
  localparam logic [3:0]         KeyClear  = 4'hC;
  localparam logic [3:0]         MaxFails  = 4'(MAX_FAILS);
  // Loads truncate silently to the timer width.
  localparam logic [TIMER_W-1:0] OpenLoad  = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] AlarmLoad = TIMER_W'(ALARM_CYCLES - 1);

  // Kept as a plain vector so that illegal codes 11-15 can be represented and recovered.
  logic [3:0]         state_q, state_d;
  logic [31:0]        seq_q, seq_d;
  logic [31:0]        pwd_q, pwd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         fail_q, fail_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               unlock_q, alarm_q;

  logic       is_digit, is_set, is_lock, is_clear;
  logic [3:0] fail_inc;
  logic [3:0] exp_digit;

  always_comb begin
    is_digit  = key_valid && (key_code <= 4'd9);
    is_set    = key_valid && (key_code == KeySet);
    is_lock   = key_valid && (key_code == KeyLock);
    is_clear  = key_valid && (key_code == KeyClear);
    fail_inc  = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
    exp_digit = pwd_q[{state_q[2:0], 2'b00} +: 4];

    state_d = state_q;
    seq_d   = seq_q;
    pwd_d   = pwd_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;

    case (state_q)
      StInit: begin
        if (is_digit && (cnt_q < 4'd8)) begin
          seq_d[{cnt_q[2:0], 2'b00} +: 4] = key_code;
          cnt_d = cnt_q + 4'd1;
        end else if (is_clear) begin
          seq_d = '0;
          cnt_d = '0;
        end else if (is_set && (cnt_q == 4'd8)) begin
          pwd_d   = seq_q;
          seq_d   = '0;
          cnt_d   = '0;
          fail_d  = '0;
          state_d = StLs0;
        end
      end

      StLs0, StLs1, StLs2, StLs3, StLs4, StLs5, StLs6, StLs7: begin
        // The LS index doubles as the position of the digit being checked.
        if (is_digit) begin
          if (key_code == exp_digit) begin
            seq_d[{state_q[2:0], 2'b00} +: 4] = key_code;
            if (state_q == StLs7) begin
              state_d = StOpen;
              timer_d = OpenLoad;
              fail_d  = '0;
            end else begin
              state_d = state_q + 4'd1;
            end
          end else begin
            fail_d = fail_inc;
            seq_d  = '0;
            if (fail_inc == MaxFails) begin
              state_d = StAlarm;
              timer_d = AlarmLoad;
            end else begin
              state_d = StLs0;
            end
          end
        end else if (is_clear || is_lock) begin
          state_d = StLs0;
          seq_d   = '0;
        end
      end

      StOpen: begin
        // Timeout takes priority over any key in the same cycle.
        if (timer_q == '0) begin
          state_d = StLs0;
          fail_d  = '0;
          seq_d   = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
          if (is_lock) begin
            state_d = StLs0;
            fail_d  = '0;
            seq_d   = '0;
            timer_d = '0;
          end else if (is_set) begin
            state_d = StInit;
            seq_d   = '0;
            cnt_d   = '0;
            timer_d = '0;
          end
        end
      end

      StAlarm: begin
        if (timer_q == '0) begin
          state_d = StLs0;
          fail_d  = '0;
          seq_d   = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      default: begin
        state_d = StInit;
        seq_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StInit;
      seq_q    <= '0;
      pwd_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      pwd_q    <= pwd_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      unlock_q <= (state_d == StOpen);
      alarm_q  <= (state_d == StAlarm);
    end
  end

  assign state  = state_q;
  assign seq    = seq_q;
  assign unlock = unlock_q;
  assign alarm  = alarm_q;

endmodule
